// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_core
//
// Transmit half of the UART loopback path. Serializes one byte per request
// into an asynchronous frame: start bit, 8 data bits LSB-first, optional
// parity bit, then 1 or 2 stop bits. The bit period is baud_max_cnt+1 mclk
// cycles and is chosen at run time. A one-cycle done pulse marks the end of
// the last stop bit.
//
// Configuration macro:
//   UART_TX_PARITY_EN  defined   : PARITY state built, parity_sel honoured
//                      undefined : no parity bit ever, parity_sel ignored
//
// Ports:
//   mclk          in   system clock, rising edge
//   n_reset       in   asynchronous active-low reset
//   baud_max_cnt  in   [15:0] bit period minus one, in mclk cycles
//   tr_data       in   [7:0]  byte to send
//   parity_sel    in   [1:0]  00 none, 01 odd, 10 even, 11 none
//   stop_sel      in   0 = one stop bit, 1 = two stop bits
//   send_en       in   start request, sampled only while idle
//   txd           out  serial line, idle high (registered)
//   done          out  one-cycle pulse at frame end (registered)
// -----------------------------------------------------------------------------
module uart_tx_core (
   input  logic        mclk,
   input  logic        n_reset,
   input  logic [15:0] baud_max_cnt,
   input  logic [7:0]  tr_data,
   input  logic [1:0]  parity_sel,
   input  logic        stop_sel,
   input  logic        send_en,
   output logic        txd,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_baud;
   logic [3:0]  r_bit_idx;
   logic [7:0]  r_data;
   logic        r_stop;
   logic        r_txd;
   logic        r_done;

   logic        w_bit_end;
   logic [2:0]  w_next_idx;

   assign w_bit_end  = (r_cnt == r_baud);
   assign w_next_idx = r_bit_idx[2:0] + 3'd1;

`ifdef UART_TX_PARITY_EN
   logic [1:0]  r_par;
   logic        w_par_en;
   logic        w_par_bit;

   assign w_par_en  = (r_par == 2'b01) || (r_par == 2'b10);
   // Odd parity is the complement of the data's XOR-reduce.
   assign w_par_bit = (r_par == 2'b01) ? ~(^r_data) : (^r_data);
`else
   logic        w_unused_parity;
   assign w_unused_parity = ^parity_sel;
`endif

   always_ff @(posedge mclk or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_stop    <= 1'b0;
         r_txd     <= 1'b1;
         r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par     <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd     <= 1'b1;
               r_cnt     <= '0;
               r_bit_idx <= '0;
               if (send_en) begin
                  // Frame settings are frozen here; later input changes are ignored.
                  r_data  <= tr_data;
                  r_stop  <= stop_sel;
                  r_baud  <= baud_max_cnt;
`ifdef UART_TX_PARITY_EN
                  r_par   <= parity_sel;
`endif
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_txd     <= r_data[0];
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit_idx == 4'd7) begin
                     r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     if (w_par_en) begin
                        r_txd   <= w_par_bit;
                        r_state <= S_PARITY;
                     end else begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                     end
`else
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                     r_txd     <= r_data[w_next_idx];
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_txd     <= 1'b1;
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
`endif

            S_STOP: begin
               r_txd <= 1'b1;
               if (w_bit_end) begin
                  r_cnt <= '0;
                  // Index 0 is the first stop bit; two-stop frames also run index 1.
                  if (r_bit_idx == {3'b000, r_stop}) begin
                     r_bit_idx <= '0;
                     r_done    <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign txd  = r_txd;
   assign done = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core. Expected frames are hand-written bit
// strings, first transmitted bit leftmost; the parity-carrying variants are
// selected by the same UART_TX_PARITY_EN macro as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

   logic        mclk;
   logic        n_reset;
   logic [15:0] baud_max_cnt;
   logic [7:0]  tr_data;
   logic [1:0]  parity_sel;
   logic        stop_sel;
   logic        send_en;
   logic        txd;
   logic        done;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   uart_tx_core dut (
      .mclk         (mclk),
      .n_reset      (n_reset),
      .baud_max_cnt (baud_max_cnt),
      .tr_data      (tr_data),
      .parity_sel   (parity_sel),
      .stop_sel     (stop_sel),
      .send_en      (send_en),
      .txd          (txd),
      .done         (done)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Sets frame inputs and raises send_en; the following rising edge starts the frame.
   task automatic start_frame(input logic [7:0] d, input logic [1:0] p,
                              input logic s, input logic [15:0] m);
      @(negedge mclk);
      tr_data      = d;
      parity_sel   = p;
      stop_sel     = s;
      baud_max_cnt = m;
      send_en      = 1'b1;
   endtask

   // Checks txd/done every cycle of a frame, the done pulse, and optionally
   // one idle cycle afterwards. With drive_inputs set, send_en is dropped and
   // all other inputs are corrupted right after the start edge.
   task automatic check_frame(input string name, input string exp,
                              input int unsigned m, input bit drive_inputs,
                              input bit idle_after);
      int unsigned n;
      int unsigned ncyc;
      logic        e;
      n    = exp.len();
      ncyc = n * (m + 1);
      for (int unsigned k = 0; k < ncyc; k++) begin
         @(negedge mclk);
         e = (exp.getc(int'(k / (m + 1))) == 8'h31);
         checks++;
         if ({txd, done} !== {e, 1'b0}) begin
            failures++;
            $display("FAIL %s cycle=%0d txd,done=%b%b expected %b0", name, k, txd, done, e);
         end
         if (k == 0 && drive_inputs) begin
            send_en      = 1'b0;
            tr_data      = ~tr_data;
            parity_sel   = ~parity_sel;
            stop_sel     = ~stop_sel;
            baud_max_cnt = baud_max_cnt + 16'd5;
         end
      end
      @(negedge mclk);
      checks++;
      if ({txd, done} !== 2'b11) begin
         failures++;
         $display("FAIL %s_done at cycle %0d txd,done=%b%b expected 11", name, ncyc, txd, done);
      end
      if (idle_after) begin
         @(negedge mclk);
         checks++;
         if ({txd, done} !== 2'b10) begin
            failures++;
            $display("FAIL %s_after txd,done=%b%b expected 10", name, txd, done);
         end
      end
   endtask

   task automatic test_reset;
      n_reset      = 1'b0;
      send_en      = 1'b0;
      tr_data      = '0;
      parity_sel   = '0;
      stop_sel     = 1'b0;
      baud_max_cnt = '0;
      #100;
      for (int i = 0; i < 3; i++) begin
         @(negedge mclk);
         checks++;
         if ({txd, done} !== 2'b10) begin
            failures++;
            $display("FAIL reset_hold txd,done=%b%b expected 10", txd, done);
         end
      end
      n_reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge mclk);
         checks++;
         if ({txd, done} !== 2'b10) begin
            failures++;
            $display("FAIL reset_idle txd,done=%b%b expected 10", txd, done);
         end
      end
   endtask

   task automatic test_frames;
      start_frame(8'h55, 2'b01, 1'b1, 16'd15);
`ifdef UART_TX_PARITY_EN
      check_frame("f55_odd_2stop", "010101010111", 15, 1, 1);
`else
      check_frame("f55_odd_2stop", "01010101011", 15, 1, 1);
`endif
      start_frame(8'hA3, 2'b10, 1'b0, 16'd3);
`ifdef UART_TX_PARITY_EN
      check_frame("fA3_even", "01100010101", 3, 1, 1);
`else
      check_frame("fA3_even", "0110001011", 3, 1, 1);
`endif
      start_frame(8'h07, 2'b10, 1'b0, 16'd1);
`ifdef UART_TX_PARITY_EN
      check_frame("f07_even", "01110000011", 1, 1, 1);
`else
      check_frame("f07_even", "0111000001", 1, 1, 1);
`endif
      start_frame(8'h0F, 2'b01, 1'b0, 16'd0);
`ifdef UART_TX_PARITY_EN
      check_frame("f0F_odd_m0", "01111000011", 0, 1, 1);
`else
      check_frame("f0F_odd_m0", "0111100001", 0, 1, 1);
`endif
      start_frame(8'h80, 2'b11, 1'b1, 16'd2);
      check_frame("f80_par11", "00000000111", 2, 1, 1);
   endtask

   task automatic test_busy_ignore;
      start_frame(8'hC1, 2'b01, 1'b1, 16'd7);
      fork
`ifdef UART_TX_PARITY_EN
         check_frame("busy_frame", "010000011011", 7, 0, 1);
`else
         check_frame("busy_frame", "01000001111", 7, 0, 1);
`endif
         begin
            @(negedge mclk);
            send_en = 1'b0;
            for (int p = 0; p < 10; p++) begin
               repeat (7) @(negedge mclk);
               send_en = 1'b1;
               tr_data = 8'hFF;
               @(negedge mclk);
               send_en = 1'b0;
            end
         end
      join
      start_frame(8'h3C, 2'b00, 1'b1, 16'd7);
      check_frame("busy_next", "00011110011", 7, 1, 1);
   endtask

   task automatic test_back_to_back;
      start_frame(8'h3C, 2'b00, 1'b0, 16'd0);
      check_frame("b2b_1", "0001111001", 0, 0, 0);
      check_frame("b2b_2", "0001111001", 0, 0, 0);
      check_frame("b2b_3", "0001111001", 0, 0, 0);
      send_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge mclk);
         checks++;
         if ({txd, done} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_idle txd,done=%b%b expected 10", txd, done);
         end
      end
   endtask

   task automatic test_mid_reset;
      start_frame(8'hA3, 2'b10, 1'b0, 16'd3);
      @(negedge mclk);
      send_en = 1'b0;
      repeat (13) @(negedge mclk);
      checks++;
      if (txd !== 1'b0) begin
         failures++;
         $display("FAIL midreset_pre txd=%b expected 0", txd);
      end
      #2 n_reset = 1'b0;
      #1;
      checks++;
      if ({txd, done} !== 2'b10) begin
         failures++;
         $display("FAIL midreset_async txd,done=%b%b expected 10", txd, done);
      end
      repeat (2) @(negedge mclk);
      n_reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge mclk);
         checks++;
         if ({txd, done} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_idle txd,done=%b%b expected 10", txd, done);
         end
      end
      start_frame(8'hA3, 2'b10, 1'b0, 16'd3);
`ifdef UART_TX_PARITY_EN
      check_frame("midreset_frame", "01100010101", 3, 1, 1);
`else
      check_frame("midreset_frame", "0110001011", 3, 1, 1);
`endif
   endtask

   initial begin
      test_reset();
      test_frames();
      test_busy_ignore();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
